// File: rtl/mem_bank_router_if.sv
// Memory port bundle: request/response handshakes for NLanes ports side by side.
// Lane i of a packed field occupies bits [i*W +: W].
interface mem_bank_router_if #(
    parameter int unsigned NLanes   = 1,
    parameter int unsigned OpqBits  = 8,
    parameter int unsigned AddrBits = 32,
    parameter int unsigned DataBits = 32
);
    localparam int unsigned ReqW = 5 + OpqBits + AddrBits;
    localparam int unsigned RspW = 5 + OpqBits;

    logic [NLanes-1:0]          memreq_val;
    logic [NLanes-1:0]          memreq_rdy;
    logic [NLanes*ReqW-1:0]     memreq_control;
    logic [NLanes*DataBits-1:0] memreq_data;
    logic [NLanes-1:0]          req_level;
    logic [NLanes-1:0]          memresp_val;
    logic [NLanes-1:0]          memresp_rdy;
    logic [NLanes*RspW-1:0]     memresp_control;
    logic [NLanes*DataBits-1:0] memresp_data;

    // Master issues requests and accepts responses.
    modport master (
        output memreq_val, memreq_control, memreq_data, req_level, memresp_rdy,
        input  memreq_rdy, memresp_val, memresp_control, memresp_data
    );

    // Slave accepts requests and issues responses.
    modport slave (
        input  memreq_val, memreq_control, memreq_data, req_level, memresp_rdy,
        output memreq_rdy, memresp_val, memresp_control, memresp_data
    );
endinterface

// File: rtl/mem_bank_router.sv
// Steers upstream requests to one of four banks by addr[15:14], squashes
// high-security writes/AMOs aimed at low-security banks, and merges bank
// responses back upstream strictly in request order via an order FIFO.
module mem_bank_router #(
    parameter int unsigned p_opaque_nbits    = 8,
    parameter int unsigned p_addr_nbits      = 32,
    parameter int unsigned p_data_nbits      = 32,
    parameter logic [3:0]  p_bank_sec        = 4'b0011,
    parameter int unsigned p_max_outstanding = 4
) (
    input logic              clk,
    input logic              reset,
    mem_bank_router_if.slave  up,
    mem_bank_router_if.master bank
);
    localparam int unsigned NBanks = 4;
    localparam int unsigned ReqW   = 5 + p_opaque_nbits + p_addr_nbits;
    localparam int unsigned RspW   = 5 + p_opaque_nbits;
    localparam int unsigned PtrW   = $clog2(p_max_outstanding);
    // Entry: {bank[1:0], deny, type[2:0], opaque, len[1:0]}; low RspW bits form a response word.
    localparam int unsigned EntW   = 3 + RspW;

    logic [2:0]                req_type;
    logic [p_opaque_nbits-1:0] req_opq;
    logic [1:0]                req_len;
    logic [1:0]                sel;
    logic                      deny;

    assign req_type = up.memreq_control[ReqW-1 -: 3];
    assign req_opq  = up.memreq_control[ReqW-4 -: p_opaque_nbits];
    assign req_len  = up.memreq_control[1:0];
    assign sel      = up.memreq_control[17:16];
    assign deny     = up.req_level[0] && !p_bank_sec[sel] &&
                      (req_type >= 3'd1) && (req_type <= 3'd5);

    logic [EntW-1:0] fifo_q [p_max_outstanding];
    logic [PtrW-1:0] head_q, head_d, tail_q, tail_d;
    logic [PtrW:0]   count_q, count_d;
    logic            full, empty, enq, deq;

    logic [EntW-1:0] head_ent;
    logic [1:0]      head_bank;
    logic            head_deny;

    assign full      = (count_q == (PtrW+1)'(p_max_outstanding));
    assign empty     = (count_q == '0);
    assign head_ent  = fifo_q[head_q];
    assign head_bank = head_ent[EntW-1 -: 2];
    assign head_deny = head_ent[EntW-3];

    logic                    req_rdy;
    logic [NBanks-1:0]       breq_val;
    logic [NBanks-1:0]       breq_lvl;
    logic                    rsp_val;
    logic [RspW-1:0]         rsp_ctl;
    logic [p_data_nbits-1:0] rsp_dat;
    logic [NBanks-1:0]       brsp_rdy;

    // Request steering; denied requests are accepted without involving any bank.
    always_comb begin
        req_rdy  = 1'b0;
        breq_val = '0;
        breq_lvl = '0;
        breq_lvl[sel] = up.req_level[0];
        if (reset) begin
            req_rdy       = !full && (deny || bank.memreq_rdy[sel]);
            breq_val[sel] = up.memreq_val[0] && !full && !deny;
        end
    end

    // Response merge: only the bank named by the FIFO head may answer.
    always_comb begin
        rsp_val  = 1'b0;
        rsp_ctl  = bank.memresp_control[head_bank*RspW +: RspW];
        rsp_dat  = bank.memresp_data[head_bank*p_data_nbits +: p_data_nbits];
        brsp_rdy = '0;
        if (reset && !empty) begin
            if (head_deny) begin
                rsp_val = 1'b1;
                rsp_ctl = head_ent[RspW-1:0];
                rsp_dat = '0;
            end else begin
                rsp_val             = bank.memresp_val[head_bank];
                brsp_rdy[head_bank] = up.memresp_rdy[0];
            end
        end
    end

    assign enq = up.memreq_val[0] && req_rdy;
    assign deq = rsp_val && up.memresp_rdy[0];

    assign up.memreq_rdy        = req_rdy;
    assign up.memresp_val       = rsp_val;
    assign up.memresp_control   = rsp_ctl;
    assign up.memresp_data      = rsp_dat;
    assign bank.memreq_val      = breq_val;
    assign bank.req_level       = breq_lvl;
    assign bank.memreq_control  = {NBanks{up.memreq_control}};
    assign bank.memreq_data     = {NBanks{up.memreq_data}};
    assign bank.memresp_rdy     = brsp_rdy;

    // Pointer/count next state; power-of-two depth makes pointer wrap implicit.
    always_comb begin
        head_d  = head_q + PtrW'(deq);
        tail_d  = tail_q + PtrW'(enq);
        count_d = count_q + (PtrW+1)'(enq) - (PtrW+1)'(deq);
    end

    // Pointer/count registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Order FIFO storage; contents are don't-care while count is zero.
    always_ff @(posedge clk) begin
        if (enq) begin
            fifo_q[tail_q] <= {sel, deny, req_type, req_opq, req_len};
        end
    end
endmodule

// File: tb/tb_mem_bank_router.sv
// Randomized bench for mem_bank_router with a transaction-level reference:
// an in-order queue of outstanding responses plus per-bank request queues.
module tb_mem_bank_router;
    localparam logic [3:0] BankSec = 4'b0011;
    localparam int unsigned Depth  = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_bank_router_if #(.NLanes(1)) up_if ();
    mem_bank_router_if #(.NLanes(4)) bk_if ();

    mem_bank_router #(
        .p_opaque_nbits   (8),
        .p_addr_nbits     (32),
        .p_data_nbits     (32),
        .p_bank_sec       (BankSec),
        .p_max_outstanding(Depth)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .up   (up_if),
        .bank (bk_if)
    );

    typedef struct packed {logic deny; logic [1:0] bank; logic [12:0] ctl;} exp_t;
    typedef struct packed {logic [12:0] ctl; logic [31:0] dat;} bresp_t;

    exp_t   exp_q[$];
    bresp_t bq[4][$];
    logic [3:0] bon;

    int n_cmp = 0;
    int n_bad = 0;

    logic        nx_reset, nx_val, nx_lvl, nx_resp_rdy, rand_bank;
    logic [44:0] nx_ctl;
    logic [31:0] nx_dat;
    logic [3:0]  resp_mask;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_req(input logic [2:0] t, input logic [7:0] o, input logic [31:0] a,
                           input logic lvl);
        nx_val = 1'b1;
        nx_lvl = lvl;
        nx_ctl = {t, o, a, 2'd0};
        nx_dat = $urandom;
    endtask

    // Compare outputs against the model, then commit the handshakes of the coming edge.
    task automatic evaluate();
        int          size;
        logic [44:0] ctl;
        logic [1:0]  sel;
        logic [2:0]  typ;
        logic        deny, full, exp_rdy, exp_rv;
        logic [3:0]  exp_bval, exp_brdy;
        exp_t        h;
        bresp_t      br;
        if (!reset) begin
            check_eq("rst_memreq_rdy", up_if.memreq_rdy, 0);
            check_eq("rst_memresp_val", up_if.memresp_val, 0);
            check_eq("rst_bank_val", bk_if.memreq_val, 0);
            check_eq("rst_bank_resp_rdy", bk_if.memresp_rdy, 0);
            exp_q.delete();
            for (int i = 0; i < 4; i++) bq[i].delete();
            bon = '0;
            return;
        end
        size = exp_q.size();
        ctl  = up_if.memreq_control;
        sel  = ctl[17:16];
        typ  = ctl[44:42];
        deny = up_if.req_level[0] && !BankSec[sel] && (typ >= 3'd1) && (typ <= 3'd5);
        full = (size == Depth);
        exp_rdy  = !full && (deny || bk_if.memreq_rdy[sel]);
        exp_bval = (up_if.memreq_val[0] && !full && !deny) ? (4'b0001 << sel) : 4'b0000;
        check_eq("memreq_rdy", up_if.memreq_rdy, exp_rdy);
        check_eq("bank_memreq_val", bk_if.memreq_val, exp_bval);
        check_eq("bank_req_level", bk_if.req_level, {3'b000, up_if.req_level[0]} << sel);
        if (exp_bval != 0) begin
            check_eq("bank_ctl_pass", bk_if.memreq_control[sel*45 +: 45], ctl);
            check_eq("bank_dat_pass", bk_if.memreq_data[sel*32 +: 32], up_if.memreq_data);
        end

        exp_rv   = 1'b0;
        exp_brdy = 4'b0000;
        if (size == 0) begin
            check_eq("empty_resp_val", up_if.memresp_val, 0);
            check_eq("empty_bank_rdy", bk_if.memresp_rdy, 0);
        end else begin
            h = exp_q[0];
            if (h.deny) begin
                exp_rv = 1'b1;
                check_eq("deny_resp_val", up_if.memresp_val, 1);
                check_eq("deny_resp_ctl", up_if.memresp_control, h.ctl);
                check_eq("deny_resp_dat", up_if.memresp_data, 0);
                check_eq("deny_bank_rdy", bk_if.memresp_rdy, 0);
            end else begin
                exp_rv   = bk_if.memresp_val[h.bank];
                exp_brdy = up_if.memresp_rdy[0] ? (4'b0001 << h.bank) : 4'b0000;
                check_eq("resp_val", up_if.memresp_val, exp_rv);
                check_eq("bank_resp_rdy", bk_if.memresp_rdy, exp_brdy);
                if (exp_rv) begin
                    br = bq[h.bank][0];
                    check_eq("resp_ctl", up_if.memresp_control, h.ctl);
                    check_eq("resp_dat", up_if.memresp_data, br.dat);
                end
            end
        end

        for (int i = 0; i < 4; i++) begin
            if (bon[i] && exp_brdy[i]) begin
                void'(bq[i].pop_front());
                bon[i] = 1'b0;
            end
        end
        if (exp_rv && up_if.memresp_rdy[0]) void'(exp_q.pop_front());
        if (up_if.memreq_val[0] && exp_rdy) begin
            exp_q.push_back('{deny: deny, bank: sel, ctl: {typ, ctl[41:34], ctl[1:0]}});
            if (!deny) begin
                bq[sel].push_back('{ctl: {typ, ctl[41:34], ctl[1:0]},
                                    dat: (ctl[33:2] == 32'h0000_4010) ? 32'hDEAD_BEEF : $urandom});
            end
        end
    endtask

    // One cycle: drive everything after the edge, check at the falling edge.
    task automatic step();
        @(posedge clk);
        #1;
        reset                   = nx_reset;
        up_if.memreq_val[0]     = nx_val;
        up_if.req_level[0]      = nx_lvl;
        up_if.memreq_control    = nx_ctl;
        up_if.memreq_data       = nx_dat;
        up_if.memresp_rdy[0]    = nx_resp_rdy;
        bk_if.memreq_rdy        = rand_bank ? 4'($urandom) : 4'hF;
        for (int i = 0; i < 4; i++) begin
            if (bq[i].size() > 0 && !bon[i] && resp_mask[i] && ($urandom_range(0, 1) == 1))
                bon[i] = 1'b1;
            bk_if.memresp_val[i] = bon[i];
            if (bq[i].size() > 0) begin
                bk_if.memresp_control[i*13 +: 13] = bq[i][0].ctl;
                bk_if.memresp_data[i*32 +: 32]    = bq[i][0].dat;
            end else begin
                bk_if.memresp_control[i*13 +: 13] = 13'($urandom);
                bk_if.memresp_data[i*32 +: 32]    = $urandom;
            end
        end
        @(negedge clk);
        evaluate();
    endtask

    task automatic drain();
        int n;
        nx_val      = 1'b0;
        nx_resp_rdy = 1'b1;
        resp_mask   = 4'hF;
        n = 0;
        while (exp_q.size() > 0 && n < 100) begin
            step();
            n++;
        end
        check_eq("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        reset = 1'b0;
        up_if.memreq_val = '0;  up_if.req_level = '0;  up_if.memresp_rdy = '0;
        up_if.memreq_control = '0;  up_if.memreq_data = '0;
        bk_if.memreq_rdy = '0;  bk_if.memresp_val = '0;
        bk_if.memresp_control = '0;  bk_if.memresp_data = '0;
        bon = '0;  rand_bank = 1'b0;  resp_mask = 4'hF;
        nx_reset = 1'b0;  nx_resp_rdy = 1'b1;
        set_req(3'd0, 8'h11, 32'h0000_4010, 1'b0);
        repeat (3) step();
        nx_reset = 1'b1;
        nx_val   = 1'b0;
        step();

        // Read to bank 1 returns the bank data with the opaque echoed.
        set_req(3'd0, 8'h5A, 32'h0000_4010, 1'b0);
        step();
        drain();

        // Banks 3, 0, 2; only bank 0 may answer, so it must stay stalled.
        resp_mask = 4'b0001;
        set_req(3'd0, 8'h01, 32'h0000_C000, 1'b0);  step();
        set_req(3'd0, 8'h02, 32'h0000_0000, 1'b0);  step();
        set_req(3'd0, 8'h03, 32'h0000_8000, 1'b0);  step();
        nx_val = 1'b0;
        repeat (6) step();
        drain();

        // Secure write to an insecure bank is squashed; to a secure bank it passes.
        set_req(3'd1, 8'h77, 32'h0000_8000, 1'b1);  step();
        nx_val = 1'b0;  step();
        drain();
        set_req(3'd1, 8'h78, 32'h0000_0000, 1'b1);  step();
        drain();

        // Fill with responses blocked; the fifth request must wait.
        nx_resp_rdy = 1'b0;
        for (int i = 0; i < 6; i++) begin
            set_req(3'd0, 8'(8'h20 + i), 32'h0000_4000 * (i % 4), 1'b0);
            step();
        end
        check_eq("full_count", exp_q.size(), Depth);
        drain();

        // Reset with three outstanding, then route normally.
        nx_resp_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_req(3'd0, 8'(8'h30 + i), 32'h0000_4000 * i, 1'b0);
            step();
        end
        nx_val = 1'b0;  nx_reset = 1'b0;  step();
        nx_reset = 1'b1;  step();
        set_req(3'd0, 8'h40, 32'h0000_C004, 1'b0);
        nx_resp_rdy = 1'b1;
        step();
        drain();

        // Random traffic with random bank readiness and occasional reset.
        rand_bank = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            nx_val      = ($urandom_range(0, 9) < 7);
            nx_lvl      = 1'($urandom);
            nx_ctl      = {3'($urandom_range(0, 7)), 8'($urandom), 32'($urandom), 2'($urandom)};
            nx_dat      = $urandom;
            nx_resp_rdy = ($urandom_range(0, 9) < 6);
            resp_mask   = 4'($urandom) | 4'b1000;
            nx_reset    = (c == 1500) ? 1'b0 : 1'b1;
            step();
        end
        nx_reset  = 1'b1;
        rand_bank = 1'b0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_bank_router.md
# mem_bank_router

Request router and in-order response merger between one L1-side memory port and four partitioned single-port test memories (the memory that serves address window `part`). Each request is steered to a bank by address bits [15:14]. The bank number is driven as that bank's `part`. Writes and AMOs from a high-security requester to a low-security bank are squashed and answered locally. Responses return to the requester strictly in request order.

## Interface
Parameters:
- p_opaque_nbits, 8, opaque field bits (o)
- p_addr_nbits, 32, address bits (a)
- p_data_nbits, 32, data bits (d)
- p_bank_sec, 4'b0011, per-bank security level; bit i is the `sec_level` of bank i
- p_max_outstanding, 4, order-FIFO depth; must be a power of 2, ≥2

Request control word is 45b: type[44:42], opaque[41:34], addr[33:2], len[1:0]. Response control word is 13b: type[12:10], opaque[9:2], len[1:0].

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low
- req_level  in  1  security level of the current request, valid with memreq_val
- memreq_val / memreq_rdy  in/out  1/1  upstream request handshake
- memreq_control  in  45  request control
- memreq_data  in  32  request data
- memresp_val / memresp_rdy  out/in  1/1  upstream response handshake
- memresp_control  out  13  response control
- memresp_data  out  32  response data
- bank_memreq_val  out  4  per-bank request valid
- bank_memreq_rdy  in  4  per-bank request ready
- bank_memreq_control  out  4×45  per-bank request control; slice i = bits [45i+44:45i]
- bank_memreq_data  out  4×32  per-bank request data
- bank_req_level  out  4  per-bank req_level
- bank_memresp_val  in  4  per-bank response valid
- bank_memresp_rdy  out  4  per-bank response ready
- bank_memresp_control  in  4×13  per-bank response control
- bank_memresp_data  in  4×32  per-bank response data

## Operation
- sel = addr[15:14].
- deny = req_level && !p_bank_sec[sel] && type ∈ {1 write, 2 write_init, 3/4/5 amo}. Reads are never denied.
- Order FIFO: p_max_outstanding entries of {bank[1:0], deny, type[2:0], opaque[7:0], len[1:0]}, with registered head/tail/count.
- memreq_rdy = !full && (deny || bank_memreq_rdy[sel]).
- bank_memreq_val[i] = memreq_val && !full && !deny && i==sel.
- All bank_memreq_control/data slices carry the upstream word unmodified.
- bank_req_level[i] = req_level when i==sel, else 0.
- Enqueue on memreq_val && memreq_rdy. A denied request never reaches a bank.
- Head is not denied:
  - memresp_val = bank_memresp_val[head.bank]
  - control and data are muxed from bank head.bank
  - bank_memresp_rdy[i] = memresp_rdy && !empty && !head.deny && i==head.bank
- Head is denied:
  - memresp_val = 1
  - control = {head.type, head.opaque, head.len}
  - data = 0
  - all bank_memresp_rdy = 0
- Empty FIFO: memresp_val = 0 and all bank_memresp_rdy = 0. A bank response arriving with no matching head entry stays stalled at the bank.
- Dequeue on memresp_val && memresp_rdy.
- Simultaneous enqueue and dequeue: count is unchanged, and both pointers advance mod p_max_outstanding.
- Full: memreq_rdy = 0 even if a dequeue occurs in the same cycle (no pass-through).
- Empty: a request enqueued this cycle is not visible at the head until the next cycle.

## Timing
- Request path is combinational, so a request reaches its bank in the acceptance cycle.
- Response path is combinational; the router adds zero cycles.
- A denied request's response is valid no earlier than the cycle after acceptance, and as soon as it reaches the head.
- Out-of-order bank responses cannot occur at the upstream port. A non-head bank's response is held with rdy=0.
- While reset=0 (asserted): head=tail=count=0 on the next edge; memreq_rdy, memresp_val, bank_memreq_val and bank_memresp_rdy are all 0.
- Reset asserted mid-operation discards all FIFO entries. The banks share the same reset, so no orphan responses remain.

## Test plan
- Read addr 0x0000_4010 (bank 1), req_level=0 → bank_memreq_val=4'b0010 in the same cycle; bank 1 response data 0xDEAD_BEEF is returned upstream with the same opaque.
- Reads to banks 3, 0, 2 back-to-back; bank 0 answers first → upstream sees bank 3's response first, and bank 0 is held with bank_memresp_rdy[0]=0 until bank 3 is dequeued.
- Write, req_level=1, addr 0x0000_8000 (bank 2, sec 0) → no bank_memreq_val; next cycle memresp_val=1, type=1, opaque echoed, data=0.
- Same write to bank 0 (sec 1) → forwarded normally with bank_req_level[0]=1.
- Five reads with memresp_rdy=0 → four accepted, memreq_rdy=0 on the fifth until one response is dequeued.
- Assert reset with three outstanding → next cycle count=0, memresp_val=0; a new read after deassertion routes normally.
